// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: tag and entry layouts for the default
// configuration, plus a small width helper used by the commit logic.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_DATA_W = 64;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  redirect;
    logic                  has_rd;
    logic [4:0]            rd;
    logic [ROB_DATA_W-1:0] value;
    logic [ROB_DATA_W-1:0] pc;
  } rob_entry_t;

  // Index width for n lanes; never zero so single-lane builds stay legal.
  function automatic int rob_lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Picks the committable prefix from head-ordered ready/redirect vectors and
// cuts the window right after the first redirecting entry.
module rob_commit_select
  import reorder_buffer_pkg::*;
#(
  parameter  int COMMIT_WIDTH = 2,
  localparam int CNT_W        = $clog2(COMMIT_WIDTH) + 1,
  localparam int LANE_W       = rob_lane_w(COMMIT_WIDTH)
) (
  input  logic [COMMIT_WIDTH-1:0] ready_i,
  input  logic [COMMIT_WIDTH-1:0] redirect_i,
  output logic [COMMIT_WIDTH-1:0] commit_mask_o,
  output logic [CNT_W-1:0]        commit_cnt_o,
  output logic                    flush_o,
  output logic [LANE_W-1:0]       flush_lane_o
);

  logic open;

  // NOTE: every output gets a default before the loop, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    commit_mask_o = '0;
    commit_cnt_o  = '0;
    flush_o       = 1'b0;
    flush_lane_o  = '0;
    open          = 1'b1;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (open && ready_i[i]) begin
        commit_mask_o[i] = 1'b1;
        commit_cnt_o     = commit_cnt_o + CNT_W'(1);
        if (redirect_i[i]) begin
          flush_o      = 1'b1;
          flush_lane_o = LANE_W'(i);
          open         = 1'b0;
        end
      end else begin
        open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates tagged entries in program order, takes
// out-of-order writebacks, and retires a done prefix from the head each cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = ROB_DEPTH,
  parameter int MULTI_ISSUE  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int WB_PORTS     = 2,
  parameter int TAG_W        = $clog2(DEPTH)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [MULTI_ISSUE-1:0]                    alloc_req_i,
  input  logic [MULTI_ISSUE-1:0]                    alloc_has_rd_i,
  input  logic [MULTI_ISSUE-1:0][4:0]               alloc_rd_i,
  output logic [$clog2(MULTI_ISSUE):0]              alloc_cnt_o,
  output logic [MULTI_ISSUE-1:0][TAG_W-1:0]         alloc_tag_o,
  input  logic [WB_PORTS-1:0]                       wb_valid_i,
  input  logic [WB_PORTS-1:0][TAG_W-1:0]            wb_tag_i,
  input  logic [WB_PORTS-1:0][DATA_WIDTH-1:0]       wb_value_i,
  input  logic [WB_PORTS-1:0]                       wb_redirect_i,
  input  logic [WB_PORTS-1:0][DATA_WIDTH-1:0]       wb_pc_i,
  output logic [COMMIT_WIDTH-1:0]                   commit_valid_o,
  output logic [COMMIT_WIDTH-1:0]                   commit_has_rd_o,
  output logic [COMMIT_WIDTH-1:0][4:0]              commit_rd_o,
  output logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]   commit_value_o,
  output logic [COMMIT_WIDTH-1:0][TAG_W-1:0]        commit_tag_o,
  output logic                                      flush_o,
  output logic [DATA_WIDTH-1:0]                     flush_pc_o,
  output logic [TAG_W:0]                            count_o,
  output logic                                      full_o,
  output logic                                      empty_o
);

  localparam int CNT_W   = TAG_W + 1;
  localparam int ACNT_W  = $clog2(MULTI_ISSUE) + 1;
  localparam int CCNT_W  = $clog2(COMMIT_WIDTH) + 1;
  localparam int CLANE_W = rob_lane_w(COMMIT_WIDTH);

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  redirect;
    logic                  has_rd;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] value;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  entry_t            entries_q [DEPTH];
  entry_t            entries_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [CNT_W-1:0]        count_eff;
  logic [CNT_W-1:0]        free_slots;
  logic [ACNT_W-1:0]       req_cnt;
  logic [CNT_W-1:0]        req_w;
  logic [ACNT_W-1:0]       grant;
  logic [TAG_W-1:0]        commit_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] win_ready;
  logic [COMMIT_WIDTH-1:0] win_redirect;
  logic [COMMIT_WIDTH-1:0] commit_mask;
  logic [CCNT_W-1:0]       commit_cnt;
  logic                    sel_flush;
  logic [CLANE_W-1:0]      sel_flush_lane;

  // While reset is held the buffer reports itself empty and retires nothing.
  always_comb begin
    count_eff = rst ? '0 : count_q;
    req_cnt   = '0;
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      req_cnt = req_cnt + ACNT_W'(alloc_req_i[i]);
    end
    free_slots = CNT_W'(DEPTH) - count_eff;
    req_w      = CNT_W'(req_cnt);
    if (sel_flush) begin
      grant = '0;
    end else if (req_w > free_slots) begin
      grant = ACNT_W'(free_slots);
    end else begin
      grant = req_cnt;
    end
  end

  always_comb begin
    for (int i = 0; i < MULTI_ISSUE; i++) begin
      alloc_tag_o[i] = tail_q + TAG_W'(i);
    end
    alloc_cnt_o = grant;
  end

  always_comb begin
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      commit_idx[l]   = head_q + TAG_W'(l);
      win_ready[l]    = !rst && entries_q[commit_idx[l]].valid && entries_q[commit_idx[l]].done;
      win_redirect[l] = entries_q[commit_idx[l]].redirect;
    end
  end

  rob_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_commit_select (
    .ready_i       (win_ready),
    .redirect_i    (win_redirect),
    .commit_mask_o (commit_mask),
    .commit_cnt_o  (commit_cnt),
    .flush_o       (sel_flush),
    .flush_lane_o  (sel_flush_lane)
  );

  always_comb begin
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      commit_valid_o[l]  = commit_mask[l];
      commit_has_rd_o[l] = entries_q[commit_idx[l]].has_rd;
      commit_rd_o[l]     = entries_q[commit_idx[l]].rd;
      commit_value_o[l]  = entries_q[commit_idx[l]].value;
      commit_tag_o[l]    = commit_idx[l];
    end
    flush_o    = sel_flush;
    flush_pc_o = sel_flush ? entries_q[head_q + TAG_W'(sel_flush_lane)].pc : '0;
    count_o    = count_eff;
    full_o     = (count_eff == CNT_W'(DEPTH));
    empty_o    = (count_eff == '0);
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    // Descending port order lets the lowest port's write land last and win.
    if (!sel_flush) begin
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && entries_q[wb_tag_i[p]].valid) begin
          entries_d[wb_tag_i[p]].done     = 1'b1;
          entries_d[wb_tag_i[p]].value    = wb_value_i[p];
          entries_d[wb_tag_i[p]].redirect = wb_redirect_i[p];
          entries_d[wb_tag_i[p]].pc       = wb_pc_i[p];
        end
      end
    end

    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      if (commit_mask[l]) begin
        entries_d[commit_idx[l]].valid = 1'b0;
      end
    end
    head_d = head_q + TAG_W'(commit_cnt);

    if (sel_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
      tail_d  = head_d;
      count_d = '0;
    end else begin
      for (int i = 0; i < MULTI_ISSUE; i++) begin
        if (ACNT_W'(i) < grant) begin
          entries_d[alloc_tag_o[i]].valid    = 1'b1;
          entries_d[alloc_tag_o[i]].done     = 1'b0;
          entries_d[alloc_tag_o[i]].redirect = 1'b0;
          entries_d[alloc_tag_o[i]].has_rd   = alloc_has_rd_i[i];
          entries_d[alloc_tag_o[i]].rd       = alloc_rd_i[i];
        end
      end
      tail_d  = tail_q + TAG_W'(grant);
      count_d = count_q + CNT_W'(grant) - CNT_W'(commit_cnt);
    end
  end

  // NOTE: only the valid bits are reset; payload fields are don't-care until
  // an entry is allocated, so they carry no reset and simply hold meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised in-order commit buffer for the out-of-order core. It sits between issue and register-file update. Issued instructions are allocated tagged entries in program order. Functional-unit broadcasts complete those entries out of order, and the buffer commits up to COMMIT_WIDTH completed entries per cycle from the head. A committed branch redirect flushes all younger entries.

## Interface
Parameters:
- DATA_WIDTH, 64, result/PC width
- DEPTH, 16, entry count; power of two, >= 2*MULTI_ISSUE
- MULTI_ISSUE, 2, allocation lanes per cycle
- COMMIT_WIDTH, 2, max commits per cycle
- WB_PORTS, 2, writeback ports
- TAG_W, $clog2(DEPTH), tag width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alloc_req_i  in  [MULTI_ISSUE]  allocation request per lane; must be a prefix (lane i set implies lanes <i set)
- alloc_has_rd_i  in  [MULTI_ISSUE]  entry writes a destination register
- alloc_rd_i  in  [MULTI_ISSUE][5]  destination register index
- alloc_cnt_o  out  $clog2(MULTI_ISSUE)+1  lanes granted this cycle (prefix)
- alloc_tag_o  out  [MULTI_ISSUE][TAG_W]  tag for lane i = tail+i mod DEPTH
- wb_valid_i  in  [WB_PORTS]  writeback strobe
- wb_tag_i  in  [WB_PORTS][TAG_W]  completing entry
- wb_value_i  in  [WB_PORTS][DATA_WIDTH]  result value
- wb_redirect_i  in  [WB_PORTS]  entry is a mispredicted branch
- wb_pc_i  in  [WB_PORTS][DATA_WIDTH]  redirect target
- commit_valid_o  out  [COMMIT_WIDTH]  prefix of committing entries
- commit_has_rd_o, commit_rd_o, commit_value_o, commit_tag_o  out  per lane  committed entry fields
- flush_o  out  1  committing entry carries a redirect
- flush_pc_o  out  DATA_WIDTH  redirect target
- count_o  out  TAG_W+1  occupied entries
- full_o, empty_o  out  1  count==DEPTH / count==0

## Operation
- State: head, tail (TAG_W, wrap mod DEPTH), count; per entry: valid, done, redirect, has_rd, rd, value, pc.
- Allocate: grant = min(popcount(alloc_req_i), DEPTH-count). Grant uses the registered count only; slots freed by same-cycle commits are not reused. New entries get valid=1, done=0, redirect=0. tail += grant.
- Writeback: for valid entries, set done, value, redirect, pc. Writebacks to invalid entries are ignored. If two ports hit the same tag in one cycle, the lowest port wins.
- Commit: from head, take consecutive valid&done entries, at most COMMIT_WIDTH. Stop after the first entry with redirect (that entry is included). head += n; count += grant - n.
- Flush: when the committing window contains a redirect, flush_o=1 and flush_pc_o=pc of that entry. Also in that cycle:
  - alloc_cnt_o=0;
  - writebacks are discarded;
  - at the edge, all entries are invalidated, tail=head+n, count=0.
- Reset: all valid cleared; head=tail=count=0. Outputs while rst is held or just after: alloc grants as empty, commit_valid_o=0, flush_o=0, empty_o=1, full_o=0, count_o=0. A reset mid-operation drops all in-flight entries with no commit.

## Timing
- alloc_cnt_o and alloc_tag_o are combinational from registered state and alloc_req_i, in the same cycle.
- Writeback at edge N makes the entry done; the earliest commit_valid_o is cycle N+1. Writeback-to-commit latency is 1 cycle. There is no same-cycle bypass.
- commit_* and flush_* are combinational from registered state. Entries retire at the end of the cycle in which commit_valid_o is shown. The consumer cannot stall commit.
- Wrap-around: tags and head wrap mod DEPTH. A full buffer is identified by count, not by pointer equality.
- Simultaneous allocate, writeback and commit in one cycle are all legal, except in a flush cycle.

## Structure
- Shared types package:
  - rob_tag_t;
  - rob_entry_t struct (valid, done, redirect, has_rd, rd, value, pc);
  - the ROB_DEPTH default constant.
- One sub-module, rob_commit_select: combinational selection of the commit prefix and redirect cut from head-ordered done/redirect vectors.

## Test plan
- Reset then allocate 2 lanes per cycle for 8 cycles with DEPTH=16 -> tags 0..15 issued, full_o=1 after cycle 8, alloc_cnt_o=0 on cycle 9.
- Allocate tags 0..3, write back 3,2,1,0 on successive cycles -> no commit until tag 0 is done. The cycle after tag 0's writeback, commit_valid_o=2'b11 (tags 0,1); next cycle tags 2,3.
- Writeback tag 1 with redirect, pc=0x400; tags 0 and 2 done -> commit tags 0,1 only, flush_o=1, flush_pc_o=0x400, count_o=0 next cycle, tag 2 never commits.
- Both WB ports write tag 5 in one cycle with values 0xA and 0xB -> the committed value is 0xA.
- Fill to 15 entries, request 2 lanes -> alloc_cnt_o=1. With head at 14, allocate across the wrap -> tags 14,15,0 are in order and commit in order.
- Assert rst with 6 entries in flight -> count_o=0, empty_o=1, and no commit_valid_o is seen afterward for the old tags.
